// File: rtl/datamemory_selftest_responder.sv
// Data memory built-in self-test: two-pass write/read-compare sweep started on a
// rising edge of startTests, reporting testDone/dutPassed like any harness sub-tester.
module datamemory_selftest_responder #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  startTests,
    output logic                  dutPassed,
    output logic                  testDone,
    output logic [15:0]           errorCount,
    output logic [ADDR_WIDTH-1:0] firstFailAddress,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_writeEnable,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic [DATA_WIDTH-1:0] mem_dataOut
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned PAT_W = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE0, S_READ0, S_WRITE1, S_READ1, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    start_q, arm_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   exp_q, exp_d;
    logic [ADDR_WIDTH-1:0]   exp_addr_q, exp_addr_d;
    logic                    cmp_vld_q, cmp_vld_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic [ADDR_WIDTH-1:0]   ffa_q, ffa_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    start_acc;
    logic                    mismatch;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic inv);
        logic [PAT_W-1:0] p;
        p = PAT_W'(a) ^ PAT_W'(32'hA5A5A5A5);
        return DATA_WIDTH'(p) ^ {DATA_WIDTH{inv}};
    endfunction

    // arm_q blocks a start level that was already high when reset released
    assign start_acc = startTests && !start_q && arm_q &&
                       (state_q == S_IDLE || state_q == S_DONE);
    assign mismatch  = cmp_vld_q && (mem_dataOut != exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start_acc) state_d = S_WRITE0;
            S_WRITE0:       if (cnt_q == LAST_WR) state_d = S_READ0;
            S_READ0:        if (cnt_q == LAST_RD) state_d = S_WRITE1;
            S_WRITE1:       if (cnt_q == LAST_WR) state_d = S_READ1;
            S_READ1:        if (cnt_q == LAST_RD) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        exp_addr_d = exp_addr_q;
        cmp_vld_d  = 1'b0;
        err_d      = err_q;
        ffa_d      = ffa_q;
        we_d       = 1'b0;
        addr_d     = '0;
        wdata_d    = '0;

        if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (err_q == '0) ffa_d = exp_addr_q;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    cnt_d = '0;
                    err_d = '0;
                    ffa_d = '0;
                end
            end
            S_WRITE0, S_WRITE1: begin
                cnt_d = (cnt_q == LAST_WR) ? '0 : cnt_q + CNT_W'(1);
            end
            S_READ0, S_READ1: begin
                cnt_d = (cnt_q == LAST_RD) ? '0 : cnt_q + CNT_W'(1);
                // The final count is a drain cycle: it only retires the last compare
                if (cnt_q != LAST_RD) begin
                    cmp_vld_d  = 1'b1;
                    exp_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    exp_d      = pattern(cnt_q[ADDR_WIDTH-1:0], state_q == S_READ1);
                end
            end
            default: ;
        endcase

        unique case (state_d)
            S_WRITE0, S_WRITE1: begin
                we_d    = 1'b1;
                addr_d  = cnt_d[ADDR_WIDTH-1:0];
                wdata_d = pattern(cnt_d[ADDR_WIDTH-1:0], state_d == S_WRITE1);
            end
            S_READ0, S_READ1: addr_d = cnt_d[ADDR_WIDTH-1:0];
            default: ;
        endcase

        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            arm_q      <= 1'b0;
            cnt_q      <= '0;
            exp_q      <= '0;
            exp_addr_q <= '0;
            cmp_vld_q  <= 1'b0;
            err_q      <= '0;
            ffa_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            start_q    <= startTests;
            arm_q      <= arm_q || !startTests;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            exp_addr_q <= exp_addr_d;
            cmp_vld_q  <= cmp_vld_d;
            err_q      <= err_d;
            ffa_q      <= ffa_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign dutPassed        = pass_q;
    assign testDone         = done_q;
    assign errorCount       = err_q;
    assign firstFailAddress = ffa_q;
    assign mem_address      = addr_q;
    assign mem_writeEnable  = we_q;
    assign mem_dataIn       = wdata_q;

endmodule

// File: tb/tb_datamemory_selftest_responder.sv
// Scoreboarded bench for the data memory self-test responder: RAM model with
// injectable faults, expected verdicts queued at start and popped at testDone.
module tb_datamemory_selftest_responder;

    localparam int D  = 128;
    localparam int D2 = 4;

    typedef struct {
        int errs;
        int first;
        bit passed;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic        pass1, done1, we1, pass2, done2, we2;
    logic [15:0] err1, err2;
    logic [6:0]  ffa1, addr1, ffa2, addr2;
    logic [31:0] din1, dout1, din2, dout2;

    logic [31:0] ram [D];
    int          fault_mode = 0;
    exp_t        sbq[$];
    int          checks = 0, failures = 0;
    int          wr_total = 0, pat_err_total = 0, wr_base = 0, pat_base = 0, viol = 0;

    always #5 clk = ~clk;

    datamemory_selftest_responder #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .MEM_DEPTH(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .startTests(start1),
        .dutPassed(pass1), .testDone(done1), .errorCount(err1), .firstFailAddress(ffa1),
        .mem_address(addr1), .mem_writeEnable(we1), .mem_dataIn(din1), .mem_dataOut(dout1)
    );

    datamemory_selftest_responder #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .MEM_DEPTH(D2)) u_small (
        .clk(clk), .rst_n(rst_n), .startTests(start2),
        .dutPassed(pass2), .testDone(done2), .errorCount(err2), .firstFailAddress(ffa2),
        .mem_address(addr2), .mem_writeEnable(we2), .mem_dataIn(din2), .mem_dataOut(dout2)
    );

    // Small instance sees a RAM that drops every write and reads back zero
    assign dout2 = 32'h0;

    function automatic logic [31:0] bp(input int a, input bit inv);
        return (32'(a) ^ 32'hA5A5A5A5) ^ (inv ? 32'hFFFF_FFFF : 32'h0);
    endfunction

    // Synchronous 1-cycle-latency RAM; mode 1: bit 0 of addr 5 stuck at 0, mode 2: reads 0
    always @(posedge clk) begin
        if (we1) ram[addr1] <= (fault_mode == 1 && addr1 == 7'd5) ? (din1 & 32'hFFFF_FFFE) : din1;
        dout1 <= (fault_mode == 2) ? 32'h0 : ram[addr1];
    end

    always @(negedge clk) begin
        int idx;
        idx = wr_total - wr_base;
        if (rst_n && we1) begin
            if (addr1 !== 7'(idx % D) || din1 !== bp(idx % D, idx >= D)) pat_err_total++;
            wr_total++;
        end
        if ((pass1 && !done1) || (pass2 && !done2)) viol++;
    end

    function automatic exp_t model(input int mode, input int depth);
        exp_t r;
        logic [31:0] pat, st;
        r.errs = 0;
        r.first = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < depth; a++) begin
                pat = bp(a, p == 1);
                st = (mode == 2) ? 32'h0 : ((mode == 1 && a == 5) ? (pat & 32'hFFFF_FFFE) : pat);
                if (st != pat) begin
                    if (r.errs == 0) r.first = a;
                    r.errs++;
                end
            end
        end
        r.passed = (r.errs == 0);
        r.lat = 4 * depth + 2;
        return r;
    endfunction

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b0; else start1 = 1'b0;
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
    endtask

    task automatic launch(input bit sel, input int mode);
        sbq.push_back(model(mode, sel ? D2 : D));
        wr_base  = wr_total;
        pat_base = pat_err_total;
        pulse_start(sel);
    endtask

    // Waits for testDone (bounded), optionally toggling startTests at cycle toggle_at
    task automatic finish_run(input bit sel, input string name, input int toggle_at);
        exp_t e;
        int n;
        bit seen;
        logic d, ps;
        logic [15:0] ec;
        logic [6:0] fa;
        e = sbq.pop_front();
        n = 0;
        seen = 0;
        @(posedge clk);
        for (int i = 1; i <= e.lat + 20; i++) begin
            @(posedge clk);
            #1;
            d  = sel ? done2 : done1;
            ps = sel ? pass2 : pass1;
            ec = sel ? err2 : err1;
            if (i == 1) begin
                checks++;
                if (d !== 1'b0 || ps !== 1'b0 || ec !== 16'h0) begin
                    failures++;
                    $display("FAIL %s_clear_on_start: done=%b passed=%b errors=%0d, required 0/0/0", name, d, ps, ec);
                end
            end
            if (i == toggle_at) start1 = 1'b0;
            if (i == toggle_at + 1) start1 = 1'b1;
            if (d === 1'b1) begin
                n = i;
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || n != e.lat) begin
            failures++;
            $display("FAIL %s_latency: done after %0d cycles (seen=%0d), required %0d", name, n, seen, e.lat);
        end
        ps = sel ? pass2 : pass1;
        ec = sel ? err2 : err1;
        fa = sel ? ffa2 : ffa1;
        checks++;
        if (ec !== 16'(e.errs)) begin
            failures++;
            $display("FAIL %s_errorCount: got %0d, required %0d", name, ec, e.errs);
        end
        checks++;
        if (fa !== 7'(e.first)) begin
            failures++;
            $display("FAIL %s_firstFailAddress: got %0d, required %0d", name, fa, e.first);
        end
        checks++;
        if (ps !== e.passed) begin
            failures++;
            $display("FAIL %s_dutPassed: got %b, required %b", name, ps, e.passed);
        end
        if (!sel) begin
            checks++;
            if (wr_total - wr_base != 2 * D || pat_err_total - pat_base != 0) begin
                failures++;
                $display("FAIL %s_write_stream: writes=%0d bad=%0d, required %0d writes 0 bad",
                         name, wr_total - wr_base, pat_err_total - pat_base, 2 * D);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ((sel ? done2 : done1) !== 1'b1 || (sel ? pass2 : pass1) !== e.passed) begin
            failures++;
            $display("FAIL %s_done_held: done=%b passed=%b, required 1/%b",
                     name, sel ? done2 : done1, sel ? pass2 : pass1, e.passed);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (done1 !== 1'b0) begin failures++; $display("FAIL %s_testDone: got %b, required 0", name, done1); end
        checks++;
        if (pass1 !== 1'b0) begin failures++; $display("FAIL %s_dutPassed: got %b, required 0", name, pass1); end
        checks++;
        if (err1 !== 16'h0) begin failures++; $display("FAIL %s_errorCount: got %0d, required 0", name, err1); end
        checks++;
        if (ffa1 !== 7'h0) begin failures++; $display("FAIL %s_firstFail: got %0d, required 0", name, ffa1); end
        checks++;
        if (we1 !== 1'b0) begin failures++; $display("FAIL %s_writeEnable: got %b, required 0", name, we1); end
        checks++;
        if (addr1 !== 7'h0) begin failures++; $display("FAIL %s_address: got %0d, required 0", name, addr1); end
        checks++;
        if (din1 !== 32'h0) begin failures++; $display("FAIL %s_dataIn: got %h, required 0", name, din1); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        checks++;
        if (done2 !== 1'b0 || err2 !== 16'h0) begin
            failures++;
            $display("FAIL reset_small: done=%b errors=%0d, required 0/0", done2, err2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ideal_ram();
        fault_mode = 0;
        launch(0, 0);
        finish_run(0, "ideal", -1);
    endtask

    task automatic test_toggle_midrun();
        launch(0, 0);
        finish_run(0, "toggle", 2 * D + 10);
    endtask

    task automatic test_reset_midrun();
        int bad;
        pulse_start(0);
        repeat (D + 10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done1 !== 1'b0 || we1 !== 1'b0 || addr1 !== 7'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_no_restart: %0d active cycles with start held, required 0", bad);
        end
        launch(0, 0);
        finish_run(0, "after_reset", -1);
    endtask

    task automatic test_restart_faulty();
        fault_mode = 1;
        launch(0, 1);
        finish_run(0, "stuck_bit", -1);
    endtask

    task automatic test_zero_ram_small();
        launch(1, 2);
        finish_run(1, "zero_ram", -1);
    endtask

    initial begin
        test_reset();
        test_ideal_ram();
        test_toggle_midrun();
        test_reset_midrun();
        test_restart_faulty();
        test_zero_ram_small();
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL passed_without_done: %0d cycles, required 0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datamemory_selftest_responder.md
# datamemory_selftest_responder

Built-in self-test engine for the data memory. It answers the test-harness start/done/passed handshake from the DUT side. On a rising edge of `startTests` it runs a two-pass write/read-compare sweep over every data memory word. It then raises `testDone` with `dutPassed` set to the verdict, so the top-level harness sees it exactly like any other `*testbenchharness` sub-tester.

## Interface
- `ADDR_WIDTH`, 7, memory address width
- `DATA_WIDTH`, 32, memory word width
- `MEM_DEPTH`, 128, number of words tested, addresses 0..MEM_DEPTH-1 (MEM_DEPTH ≤ 2^ADDR_WIDTH, ≥ 2)
- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `startTests` in 1 — run request; rising edge starts a test
- `dutPassed` out 1 — verdict, meaningful only while `testDone`=1
- `testDone` out 1 — test complete; held until next accepted start
- `errorCount` out 16 — mismatches in the current/last run, saturating at 16'hFFFF
- `firstFailAddress` out ADDR_WIDTH — address of the first mismatch in the last run
- `mem_address` out ADDR_WIDTH — memory address
- `mem_writeEnable` out 1 — memory write strobe
- `mem_dataIn` out DATA_WIDTH — write data to memory
- `mem_dataOut` in DATA_WIDTH — read data from memory, valid one cycle after address is presented

## Operation
- Pattern: P(a) = zero-extended `a` XOR 32'hA5A5A5A5, truncated to DATA_WIDTH. Pass 0 uses P(a); pass 1 uses ~P(a).
- Start detect: `startTests` is registered as `start_q`; a start is accepted when `startTests`=1, `start_q`=0 and state is IDLE or DONE. Edges are ignored in every other state.
- Accepting a start clears `testDone`, `dutPassed`, `errorCount` and `firstFailAddress`, loads address counter = 0, and enters WRITE0.
- States and transitions:
  - IDLE → WRITE0 on an accepted start.
  - WRITE0: `mem_writeEnable`=1, `mem_address`=a, `mem_dataIn`=P(a); a increments each cycle. After a=MEM_DEPTH-1: a=0, → READ0.
  - READ0: `mem_writeEnable`=0, `mem_address`=a. The expected value P(a) and a valid flag are pipelined one cycle. On the next cycle `mem_dataOut` is compared with the expected value. The state lasts MEM_DEPTH+1 cycles; the extra cycle drains the last compare and issues no new address. → WRITE1.
  - WRITE1: as WRITE0 with ~P(a). → READ1.
  - READ1: as READ0 with ~P(a). → DONE.
  - DONE: `testDone`=1, `dutPassed`=(errorCount==0). Stays in DONE until an accepted start.
- Mismatch: `errorCount` increments, saturating at FFFF. On the first mismatch of a run, `firstFailAddress` is set to the compared address. It is never overwritten within that run.
- `mem_writeEnable`=0 in IDLE, READ*, DONE. `mem_address` and `mem_dataIn` are don't-care when not writing, and are driven 0 in IDLE/DONE.

## Timing
- Reset values: `dutPassed`=0, `testDone`=0, `errorCount`=0, `firstFailAddress`=0, `mem_writeEnable`=0, `mem_address`=0, `mem_dataIn`=0; state IDLE; `start_q`=0.
- Reset mid-run aborts immediately: the FSM returns to IDLE and memory contents are left as-is. After reset is released, `startTests` already high does not start a run. A fresh 0→1 edge is required.
- Latency: in the accept cycle C, the state goes to WRITE0 at edge C+1. `testDone` rises at edge C+1+4·MEM_DEPTH+2, which is 515 cycles after accept for MEM_DEPTH=128.
- `testDone` and `dutPassed` change on the same edge. `dutPassed` is never 1 while `testDone`=0.
- A compare in the final READ1 drain cycle is reflected in `errorCount` on the same edge that `testDone` rises.
- Start in the same cycle that DONE is entered is not accepted, because state ≠ DONE at sampling. A start during DONE is accepted, and `testDone` falls on the next edge.

## Test plan
- Ideal 1-cycle-latency RAM model, MEM_DEPTH=128, pulse `startTests` 0→1 → `testDone` rises exactly 515 cycles after the accept edge, `dutPassed`=1, `errorCount`=0.
- RAM with bit 0 of address 5 stuck at 0, MEM_DEPTH=8 → P(5)=A5A5A5A0 has bit 0 = 0, so pass 0 matches and pass 1 fails at addr 5. Result: `errorCount`=1, `firstFailAddress`=5, `dutPassed`=0.
- RAM ignoring all writes, returning 0, MEM_DEPTH=4 → `errorCount`=8, `firstFailAddress`=0, `dutPassed`=0, `testDone`=1 after 18 cycles.
- Toggle `startTests` 1→0→1 mid-WRITE1 → no restart; completion still occurs at the original cycle count with the correct verdict.
- Assert `rst_n`=0 during READ0 while holding `startTests`=1 → all outputs return to reset values asynchronously; no run after release until `startTests` drops and rises again.
- After a passed run, apply a new start edge with the faulty RAM from the stuck-bit scenario → `testDone` drops the next cycle, `errorCount` restarts from 0, and the final verdict is `dutPassed`=0.
